// File: rtl/sap1_display_pkg.sv
// Shared definitions for the SAP-1 decimal display driver.
//   conv_state_e : converter FSM states
//   NUM_DIGITS   : number of multiplexed 7-segment digits
//   BCD_W        : width of the packed BCD field (hundreds/tens/ones)
//   seg_lut()    : digit 0..9 -> active-high gfedcba pattern
package sap1_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } conv_state_e;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned BCD_W      = 12;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_lut(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_lut = 7'b0111111;
      4'd1:    seg_lut = 7'b0000110;
      4'd2:    seg_lut = 7'b1011011;
      4'd3:    seg_lut = 7'b1001111;
      4'd4:    seg_lut = 7'b1100110;
      4'd5:    seg_lut = 7'b1101101;
      4'd6:    seg_lut = 7'b1111101;
      4'd7:    seg_lut = 7'b0000111;
      4'd8:    seg_lut = 7'b1111111;
      4'd9:    seg_lut = 7'b1101111;
      default: seg_lut = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/sap1_display_driver_if.sv
// Handshake between the display driver and its binary-to-BCD engine.
//   start : request a conversion of bin (honoured only while idle)
//   bin   : 8-bit binary value to convert
//   busy  : engine is not idle
//   done  : one-cycle strobe, bcd/value are valid
//   bcd   : packed {hundreds, tens, ones}
//   value : the binary value that produced bcd
interface sap1_display_driver_if;
  import sap1_display_pkg::*;

  logic             start;
  logic [7:0]       bin;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd;
  logic [7:0]       value;

  modport master (output start, output bin, input busy, input done, input bcd, input value);
  modport slave  (input start, input bin, output busy, output done, output bcd, output value);
endinterface

// File: rtl/sap1_bin2bcd.sv
// Sequential 8-bit double-dabble converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   conv       : slave side of the converter handshake
// Start in IDLE loads the operand, eight CONV cycles perform the
// add-3/shift iterations, LATCH presents the result with done=1.
module sap1_bin2bcd
  import sap1_display_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  sap1_display_driver_if.slave  conv
);

  conv_state_e      state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q,   bcd_d;
  logic [2:0]       iter_q,  iter_d;
  logic [7:0]       value_q, value_d;
  logic [BCD_W-1:0] adj;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    value_d = value_q;

    adj = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (conv.start) begin
          shift_d = conv.bin;
          value_d = conv.bin;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = LATCH;
      end
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      value_q <= value_d;
    end
  end

  assign conv.busy  = (state_q != IDLE);
  assign conv.done  = (state_q == LATCH);
  assign conv.bcd   = bcd_q;
  assign conv.value = value_q;

endmodule

// File: rtl/sap1_display_driver.sv
// Shows the SAP-1 output register value as decimal 000..255 on a
// 3-digit multiplexed 7-segment display.
//   CLK     : clock, rising edge
//   nCLR    : asynchronous active-low reset
//   display : 8-bit value from the output register
//   seg     : segments, seg[0]=a .. seg[6]=g
//   an      : one-hot digit enable, an[0]=ones .. an[2]=hundreds
//   busy    : conversion in progress
module sap1_display_driver
  import sap1_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          BLANK_LZ       = 1'b1
) (
  input  logic       CLK,
  input  logic       nCLR,
  input  logic [7:0] display,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  sap1_display_driver_if conv_if ();

  sap1_bin2bcd u_bin2bcd (
    .clk   (CLK),
    .rst_n (nCLR),
    .conv  (conv_if)
  );

  logic [7:0]       in_q,    in_d;
  logic [7:0]       shown_q, shown_d;
  logic [BCD_W-1:0] dig_q,   dig_d;
  logic [15:0]      presc_q, presc_d;
  logic [1:0]       idx_q,   idx_d;

  // The engine only accepts start while idle, so the latest sample is
  // re-compared after every LATCH and the final value always wins.
  assign conv_if.start = !conv_if.busy && (in_q != shown_q);
  assign conv_if.bin   = in_q;

  always_comb begin
    in_d    = display;
    shown_d = shown_q;
    dig_d   = dig_q;
    presc_d = presc_q + 16'd1;
    idx_d   = idx_q;

    if (conv_if.done) begin
      dig_d   = conv_if.bcd;
      shown_d = conv_if.value;
    end

    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      in_q    <= '0;
      shown_q <= '0;
      dig_q   <= '0;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      in_q    <= in_d;
      shown_q <= shown_d;
      dig_q   <= dig_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  logic [3:0] digit;
  logic       blank;
  logic [6:0] seg_on;
  logic [2:0] an_on;

  always_comb begin
    digit = dig_q[3:0];
    blank = 1'b0;
    an_on = 3'b001;
    case (idx_q)
      2'd1: begin
        digit = dig_q[7:4];
        blank = BLANK_LZ && (dig_q[11:4] == 8'd0);
        an_on = 3'b010;
      end
      2'd2: begin
        digit = dig_q[11:8];
        blank = BLANK_LZ && (dig_q[11:8] == 4'd0);
        an_on = 3'b100;
      end
      default: ;
    endcase
    seg_on = blank ? SEG_BLANK : seg_lut(digit);
  end

  assign seg  = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
  assign an   = AN_ACTIVE_LOW  ? ~an_on  : an_on;
  assign busy = conv_if.busy;

endmodule

// File: tb/tb_sap1_display_driver.sv
module tb_sap1_display_driver;

  logic       CLK  = 1'b0;
  logic       nCLR = 1'b1;
  logic [7:0] display = 8'd0;

  logic [6:0] seg1, seg2;
  logic [2:0] an1,  an2;
  logic       busy1, busy2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  sap1_display_driver #(
    .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
  ) dut (
    .CLK(CLK), .nCLR(nCLR), .display(display), .seg(seg1), .an(an1), .busy(busy1)
  );

  sap1_display_driver #(
    .SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)
  ) dut2 (
    .CLK(CLK), .nCLR(nCLR), .display(display), .seg(seg2), .an(an2), .busy(busy2)
  );

  // Reference model: value shown is whatever was captured 10 edges after
  // sampling; scan position follows edges since reset.
  logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                           7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  int in_m = 0, shown_m = 0, cap_m = 0, cnt_m = 0, cyc_m = 0;

  always @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      in_m <= 0; shown_m <= 0; cap_m <= 0; cnt_m <= 0; cyc_m <= 0;
    end else begin
      in_m  <= int'(display);
      cyc_m <= cyc_m + 1;
      if (cnt_m == 0) begin
        if (in_m != shown_m) begin
          cap_m <= in_m;
          cnt_m <= 9;
        end
      end else begin
        cnt_m <= cnt_m - 1;
        if (cnt_m == 1) shown_m <= cap_m;
      end
    end
  end

  function automatic logic [6:0] exp_seg(input int val, input int idx, input bit blz, input bit al);
    int d;
    bit blank;
    logic [6:0] p;
    d = (idx == 0) ? val % 10 : (idx == 1) ? (val / 10) % 10 : val / 100;
    blank = blz && ((idx == 2 && val < 100) || (idx == 1 && val < 10));
    p = blank ? 7'b0000000 : pat[d];
    return al ? ~p : p;
  endfunction

  function automatic logic [2:0] exp_an(input int idx, input bit al);
    logic [2:0] a;
    a = 3'b001 << idx;
    return al ? ~a : a;
  endfunction

  function automatic logic [10:0] exp1();
    int idx;
    idx = (cyc_m / 4) % 3;
    return {exp_seg(shown_m, idx, 1'b1, 1'b1), exp_an(idx, 1'b1), cnt_m != 0};
  endfunction

  function automatic logic [10:0] exp2();
    int idx;
    idx = cyc_m % 3;
    return {exp_seg(shown_m, idx, 1'b0, 1'b0), exp_an(idx, 1'b0), cnt_m != 0};
  endfunction

  task automatic test_reset;
    #1 nCLR = 1'b0;
    repeat (2) @(negedge CLK);
    nCLR = 1'b1;
    repeat (5) @(negedge CLK);
    @(posedge CLK);
    #2 nCLR = 1'b0;
    #1;
    n_checks++;
    if ({seg1, an1, busy1} !== {7'b1000000, 3'b110, 1'b0})
      $display("FAIL reset_async seg=%b an=%b busy=%b want seg=1000000 an=110 busy=0", seg1, an1, busy1);
    else n_pass++;
    n_checks++;
    if ({seg2, an2, busy2} !== {7'b0111111, 3'b001, 1'b0})
      $display("FAIL reset_async_dut2 seg=%b an=%b busy=%b want seg=0111111 an=001 busy=0", seg2, an2, busy2);
    else n_pass++;
    @(negedge CLK);
    nCLR = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({seg1, an1, busy1} !== exp1())
        $display("FAIL reset_idle cyc=%0d got %b want %b", c, {seg1, an1, busy1}, exp1());
      else n_pass++;
    end
  endtask

  task automatic test_full_scale;
    int first_busy, n_busy, k, run;
    first_busy = -1;
    n_busy = 0;
    display = 8'd255;
    for (int c = 1; c <= 24; c++) begin
      @(negedge CLK);
      if (busy1 && first_busy < 0) first_busy = c;
      if (busy1) n_busy++;
      n_checks++;
      if ({seg1, an1, busy1} !== exp1())
        $display("FAIL full_scale cyc=%0d got %b want %b", c, {seg1, an1, busy1}, exp1());
      else n_pass++;
    end
    n_checks++;
    if (first_busy !== 2 || n_busy !== 9)
      $display("FAIL busy_window first=%0d count=%0d want first=2 count=9", first_busy, n_busy);
    else n_pass++;
    // Find the start of a ones phase, then measure its length and digits.
    k = 0;
    while (an1 === 3'b110 && k < 20) begin @(negedge CLK); k++; end
    while (an1 !== 3'b110 && k < 40) begin @(negedge CLK); k++; end
    n_checks++;
    if (seg1 !== ~7'b1101101)
      $display("FAIL full_scale_ones got seg=%b want %b", seg1, ~7'b1101101);
    else n_pass++;
    run = 0;
    while (an1 === 3'b110 && run < 20) begin @(negedge CLK); run++; end
    n_checks++;
    if (run !== 4 || an1 !== 3'b101 || seg1 !== ~7'b1101101)
      $display("FAIL full_scale_tens run=%0d an=%b seg=%b want run=4 an=101 seg=%b", run, an1, seg1, ~7'b1101101);
    else n_pass++;
    repeat (4) @(negedge CLK);
    n_checks++;
    if (an1 !== 3'b011 || seg1 !== ~7'b1011011)
      $display("FAIL full_scale_hundreds an=%b seg=%b want an=011 seg=%b", an1, seg1, ~7'b1011011);
    else n_pass++;
  endtask

  task automatic test_blanking;
    logic [7:0] vals [3] = '{8'd7, 8'd13, 8'd100};
    // Per value: active-high pattern for ones, tens, hundreds.
    logic [6:0] tab [3][3] = '{'{7'b0000111, 7'b0000000, 7'b0000000},
                               '{7'b1001111, 7'b0000110, 7'b0000000},
                               '{7'b0111111, 7'b0111111, 7'b0000110}};
    logic [2:0] an_want;
    int k;
    for (int v = 0; v < 3; v++) begin
      display = vals[v];
      for (int c = 0; c < 16; c++) begin
        @(negedge CLK);
        n_checks++;
        if ({seg1, an1, busy1} !== exp1())
          $display("FAIL blanking val=%0d cyc=%0d got %b want %b", vals[v], c, {seg1, an1, busy1}, exp1());
        else n_pass++;
      end
      for (int d = 0; d < 3; d++) begin
        an_want = ~(3'b001 << d);
        k = 0;
        while (an1 !== an_want && k < 16) begin @(negedge CLK); k++; end
        n_checks++;
        if (an1 !== an_want || seg1 !== ~tab[v][d])
          $display("FAIL blank_digit val=%0d digit=%0d an=%b seg=%b want an=%b seg=%b",
                   vals[v], d, an1, seg1, an_want, ~tab[v][d]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
    int k;
    for (int c = 0; c < 34; c++) begin
      if (c < 4) display = seq[c];
      @(negedge CLK);
      n_checks++;
      if ({seg1, an1, busy1} !== exp1())
        $display("FAIL back_to_back cyc=%0d got %b want %b", c, {seg1, an1, busy1}, exp1());
      else n_pass++;
    end
    k = 0;
    while (an1 !== 3'b110 && k < 16) begin @(negedge CLK); k++; end
    n_checks++;
    if (busy1 !== 1'b0 || seg1 !== ~7'b0000111)
      $display("FAIL back_to_back_final busy=%b seg=%b want busy=0 seg=%b", busy1, seg1, ~7'b0000111);
    else n_pass++;
  endtask

  task automatic test_reset_mid_conv;
    int k;
    display = 8'd200;
    repeat (6) @(posedge CLK);
    #2 nCLR = 1'b0;
    #1;
    n_checks++;
    if ({seg1, an1, busy1} !== {7'b1000000, 3'b110, 1'b0})
      $display("FAIL reset_mid_conv seg=%b an=%b busy=%b want seg=1000000 an=110 busy=0", seg1, an1, busy1);
    else n_pass++;
    @(negedge CLK);
    nCLR = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({seg1, an1, busy1} !== exp1())
        $display("FAIL reconvert cyc=%0d got %b want %b", c, {seg1, an1, busy1}, exp1());
      else n_pass++;
    end
    k = 0;
    while (an1 !== 3'b011 && k < 16) begin @(negedge CLK); k++; end
    n_checks++;
    if (an1 !== 3'b011 || seg1 !== ~7'b1011011)
      $display("FAIL reconvert_hundreds an=%b seg=%b want an=011 seg=%b", an1, seg1, ~7'b1011011);
    else n_pass++;
  endtask

  task automatic test_params;
    logic [2:0] prev;
    display = 8'd5;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({seg2, an2, busy2} !== exp2())
        $display("FAIL params cyc=%0d got %b want %b", c, {seg2, an2, busy2}, exp2());
      else n_pass++;
    end
    for (int c = 0; c < 6; c++) begin
      prev = an2;
      @(negedge CLK);
      n_checks++;
      if (an2 !== {prev[1:0], prev[2]} ||
          seg2 !== ((an2 === 3'b001) ? 7'b1101101 : 7'b0111111))
        $display("FAIL params_rotate prev=%b an=%b seg=%b", prev, an2, seg2);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    int hold;
    for (int s = 0; s < 40; s++) begin
      display = 8'($urandom_range(0, 255));
      hold = (s % 4 == 0) ? 14 : int'($urandom_range(1, 12));
      for (int c = 0; c < hold; c++) begin
        @(negedge CLK);
        n_checks++;
        if ({seg1, an1, busy1} !== exp1())
          $display("FAIL random seg=%0d cyc=%0d got %b want %b", s, c, {seg1, an1, busy1}, exp1());
        else n_pass++;
        n_checks++;
        if ({seg2, an2, busy2} !== exp2())
          $display("FAIL random_dut2 seg=%0d cyc=%0d got %b want %b", s, c, {seg2, an2, busy2}, exp2());
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_blanking();
    test_back_to_back();
    test_reset_mid_conv();
    test_params();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
